controle_varredura: RTL and testbench

Sweep controller placed directly upstream of the servo PWM stage. It drives that stage's `direita`/`esquerda` step inputs so the servo sweeps back and forth over positions 0..3 without operator input. It keeps its own copy of the position (`pos_est`), can pause, and parks the servo at position 0 when sweeping is disabled.

---
 rtl/varredura_pkg.sv | 22 ++
 rtl/temporizador_passo.sv | 32 +++
 rtl/controle_varredura.sv | 134 +++++++++++++
 tb/tb_controle_varredura.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/varredura_pkg.sv
// Shared definitions for the servo sweep controller: state codes, step interval and position range.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package varredura_pkg;

    // State codes are visible on db_estado; 2'b11 is unused and recovers to INICIAL
    typedef enum logic [1:0] {
        INICIAL = 2'b00,
        VARRE   = 2'b01,
        RETORNO = 2'b10
    } estado_t;

    // 0.5 s between steps at 50 MHz
    localparam int INTERVALO_PADRAO = 25_000_000;

    // Short interval used in simulation so a full sweep fits in a few dozen cycles
    localparam int INTERVALO_SIM = 4;

    // Highest servo position; the lowest is always 0
    localparam logic [1:0] POS_MAX = 2'd3;

endpackage

// File: rtl/temporizador_passo.sv
// Step interval timer: counts 0..M-1 while enabled and flags the last count.
// Latency: fim is combinational from the registered count; wraps to 0 on the edge after fim when enabled.
// Backpressure: conta=0 freezes the count; zera clears it and takes priority over conta.
module temporizador_passo #(
    parameter int M = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic zera,
    input  logic conta,
    output logic fim
);

    localparam int W = $clog2(M);
    localparam logic [W-1:0] ULTIMO = W'(M - 1);

    logic [W-1:0] contagem;

    // Free-running modulo-M counter, gated by conta and cleared by zera
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            contagem <= '0;
        end else if (zera) begin
            contagem <= '0;
        end else if (conta) begin
            contagem <= fim ? '0 : contagem + W'(1);
        end
    end

    assign fim = (contagem == ULTIMO);

endmodule

// File: rtl/controle_varredura.sv
// Sweep controller: steps the servo 0..pos_max and back via one-cycle direita/esquerda pulses, parks at 0 when disabled.
// Latency: first direita is registered intervalo edges after the edge that moves INICIAL to VARRE.
// Backpressure: pausa freezes the interval timer in VARRE (steps deferred, never dropped); ignored in RETORNO.
module controle_varredura
    import varredura_pkg::*;
#(
    parameter int         intervalo = INTERVALO_PADRAO,
    parameter logic [1:0] pos_max   = POS_MAX
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       liga,
    input  logic       pausa,
    output logic       direita,
    output logic       esquerda,
    output logic [1:0] pos_est,
    output logic       sentido,
    output logic       fim_ciclo,
    output logic [1:0] db_estado
);

    estado_t    estado;
    logic       fim;
    logic       conta;
    logic       zera;
    logic       expira;
    logic [1:0] pos_mais;
    logic [1:0] pos_menos;

    temporizador_passo #(
        .M (intervalo)
    ) u_temporizador (
        .clock (clock),
        .reset (reset),
        .zera  (zera),
        .conta (conta),
        .fim   (fim)
    );

    // Timer control: held at 0 while idle and on every VARRE<->RETORNO change; runs only when a step is possible
    always_comb begin
        conta = 1'b0;
        zera  = 1'b0;
        case (estado)
            VARRE: begin
                conta = !pausa;
                zera  = !liga;
            end
            RETORNO: begin
                conta = (pos_est != 2'd0);
                zera  = liga || (pos_est == 2'd0);
            end
            default: begin
                zera  = 1'b1;
            end
        endcase
    end

    // A step is due when the timer sits on its last count and is allowed to advance this cycle
    assign expira    = fim && conta;
    assign pos_mais  = pos_est + 2'd1;
    assign pos_menos = pos_est - 2'd1;
    assign db_estado = estado;

    // Sweep FSM with registered pulses, position and direction; pulses default low so each lasts one cycle
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado    <= INICIAL;
            direita   <= 1'b0;
            esquerda  <= 1'b0;
            fim_ciclo <= 1'b0;
            pos_est   <= 2'd0;
            sentido   <= 1'b0;
        end else begin
            direita   <= 1'b0;
            esquerda  <= 1'b0;
            fim_ciclo <= 1'b0;
            case (estado)
                INICIAL: begin
                    pos_est <= 2'd0;
                    sentido <= 1'b0;
                    if (liga) begin
                        estado <= VARRE;
                    end
                end
                VARRE: begin
                    // Range guards keep the servo inside 0..pos_max even if sentido were inconsistent
                    if (expira) begin
                        if (!sentido && (pos_est != pos_max)) begin
                            direita <= 1'b1;
                            pos_est <= pos_mais;
                            if (pos_mais == pos_max) begin
                                sentido <= 1'b1;
                            end
                        end else if (sentido && (pos_est != 2'd0)) begin
                            esquerda <= 1'b1;
                            pos_est  <= pos_menos;
                            if (pos_menos == 2'd0) begin
                                sentido   <= 1'b0;
                                fim_ciclo <= 1'b1;
                            end
                        end
                    end
                    // Disabling heads home downwards; a step due on this same edge still goes out
                    if (!liga) begin
                        estado  <= RETORNO;
                        sentido <= 1'b1;
                    end
                end
                RETORNO: begin
                    if (pos_est == 2'd0) begin
                        estado  <= INICIAL;
                        sentido <= 1'b0;
                    end else begin
                        if (expira) begin
                            esquerda <= 1'b1;
                            pos_est  <= pos_menos;
                        end
                        // Re-enabling resumes the sweep still descending
                        if (liga) begin
                            estado <= VARRE;
                        end
                    end
                end
                default: begin
                    estado  <= INICIAL;
                    pos_est <= 2'd0;
                    sentido <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_controle_varredura.sv
// Directed bench for the sweep controller with a 4-cycle step interval.
// Latency: checks pulse timing against absolute edge counts.
// Backpressure: exercises pausa, liga drop/raise and asynchronous reset mid-pulse.
module tb_controle_varredura;
    import varredura_pkg::*;

    logic       clock;
    logic       reset;
    logic       liga;
    logic       pausa;
    logic       direita;
    logic       esquerda;
    logic [1:0] pos_est;
    logic       sentido;
    logic       fim_ciclo;
    logic [1:0] db_estado;

    int checks = 0;
    int erros  = 0;
    int n_ciclo = 0;
    int viol_retorno = 0;
    int ambos = 0;

    // One full sweep: D,D,D,E,E,E with positions and direction after each step
    int tab_dir  [6] = '{1, 1, 1, 0, 0, 0};
    int tab_pos  [6] = '{1, 2, 3, 2, 1, 0};
    int tab_sent [6] = '{0, 0, 1, 1, 1, 0};
    int tab_fim  [6] = '{0, 0, 0, 0, 0, 1};

    controle_varredura #(
        .intervalo (INTERVALO_SIM),
        .pos_max   (POS_MAX)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .liga      (liga),
        .pausa     (pausa),
        .direita   (direita),
        .esquerda  (esquerda),
        .pos_est   (pos_est),
        .sentido   (sentido),
        .fim_ciclo (fim_ciclo),
        .db_estado (db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Absolute edge count; after edge N (plus #1) n_ciclo reads N
    always @(posedge clock) n_ciclo <= n_ciclo + 1;

    // Monitors: no direita/fim_ciclo while in RETORNO, never both step pulses together
    always @(negedge clock) begin
        if (db_estado == 2'b10 && (direita || fim_ciclo)) viol_retorno++;
        if (direita && esquerda) ambos++;
    end

    task automatic verifica(input string tag, input int obtido, input int esperado);
        checks++;
        if (obtido != esperado) begin
            erros++;
            $display("FAIL %s obtido=%0d esperado=%0d", tag, obtido, esperado);
        end
    endtask

    task automatic ciclo();
        @(posedge clock);
        #1;
    endtask

    // Advance until a step pulse is visible; bounded so a dead DUT still reaches the summary
    task automatic espera_pulso(output int quando, output int d, output int e, output int f);
        quando = -1;
        d = 0;
        e = 0;
        f = 0;
        for (int k = 0; k < 20; k++) begin
            ciclo();
            if (direita || esquerda) begin
                quando = n_ciclo;
                d = int'(direita);
                e = int'(esquerda);
                f = int'(fim_ciclo);
                return;
            end
        end
        verifica("timeout_pulso", int'(direita | esquerda), 1);
    endtask

    initial begin
        int t, d, e, f, ultimo, ocioso, rel;

        // Reset with liga=0: everything parked and quiet
        reset = 1'b0;
        liga  = 1'b0;
        pausa = 1'b0;
        ciclo();
        ciclo();
        verifica("reset_direita",  int'(direita),   0);
        verifica("reset_esquerda", int'(esquerda),  0);
        verifica("reset_pos",      int'(pos_est),   0);
        verifica("reset_sentido",  int'(sentido),   0);
        verifica("reset_fim",      int'(fim_ciclo), 0);
        verifica("reset_estado",   int'(db_estado), 0);
        reset = 1'b1;
        ocioso = 0;
        for (int k = 0; k < 20; k++) begin
            ciclo();
            if (direita || esquerda || fim_ciclo || sentido || pos_est != 2'd0 || db_estado != 2'd0)
                ocioso++;
        end
        verifica("ocioso_liga0", ocioso, 0);

        // Steady sweep: 30 steps, 4 cycles apart, first one 4 edges after entering VARRE
        liga = 1'b1;
        ciclo();
        verifica("varre_apos_liga", int'(db_estado), 1);
        ultimo = n_ciclo;
        for (int i = 0; i < 30; i++) begin
            espera_pulso(t, d, e, f);
            verifica("espacamento", t - ultimo, 4);
            ultimo = t;
            verifica("passo_direita",  d, tab_dir[i % 6]);
            verifica("passo_esquerda", e, 1 - tab_dir[i % 6]);
            verifica("passo_pos",      int'(pos_est), tab_pos[i % 6]);
            verifica("passo_sentido",  int'(sentido), tab_sent[i % 6]);
            verifica("passo_fim",      f, tab_fim[i % 6]);
            ciclo();
            verifica("largura_pulso", int'(direita | esquerda | fim_ciclo), 0);
        end

        // Pause at pos 2 ascending with the timer at 2: frozen 10 cycles, then 2 more cycles to the step
        espera_pulso(t, d, e, f);
        verifica("pre_pausa_pos1", int'(pos_est), 1);
        espera_pulso(t, d, e, f);
        verifica("pre_pausa_pos2", int'(pos_est), 2);
        ciclo();
        ciclo();
        pausa = 1'b1;
        ocioso = 0;
        for (int k = 0; k < 10; k++) begin
            ciclo();
            if (direita || esquerda) ocioso++;
        end
        verifica("pausa_sem_pulso", ocioso, 0);
        pausa = 1'b0;
        rel = n_ciclo;
        espera_pulso(t, d, e, f);
        verifica("pausa_resto", t - rel, 2);
        verifica("pausa_direita", d, 1);
        verifica("pausa_pos3", int'(pos_est), 3);
        verifica("pausa_sentido", int'(sentido), 1);

        // Drop liga at pos 3: three esquerda pulses home, then INICIAL
        liga = 1'b0;
        ciclo();
        verifica("retorno_estado", int'(db_estado), 2);
        verifica("retorno_sentido", int'(sentido), 1);
        ultimo = n_ciclo;
        for (int i = 0; i < 3; i++) begin
            espera_pulso(t, d, e, f);
            verifica("retorno_espaco", t - ultimo, 4);
            ultimo = t;
            verifica("retorno_esquerda", e, 1);
            verifica("retorno_fim", f, 0);
            verifica("retorno_pos", int'(pos_est), 2 - i);
        end
        ciclo();
        verifica("retorno_inicial", int'(db_estado), 0);
        verifica("retorno_pos0", int'(pos_est), 0);
        verifica("retorno_sent0", int'(sentido), 0);

        // Drop liga at pos 2, re-raise after first esquerda: sweep resumes descending
        liga = 1'b1;
        espera_pulso(t, d, e, f);
        verifica("r2_pos1", int'(pos_est), 1);
        espera_pulso(t, d, e, f);
        verifica("r2_pos2", int'(pos_est), 2);
        liga = 1'b0;
        ciclo();
        verifica("r2_retorno", int'(db_estado), 2);
        espera_pulso(t, d, e, f);
        verifica("r2_esq1", e, 1);
        verifica("r2_esq1_pos", int'(pos_est), 1);
        liga = 1'b1;
        ciclo();
        verifica("r2_varre", int'(db_estado), 1);
        verifica("r2_sentido", int'(sentido), 1);
        rel = n_ciclo;
        espera_pulso(t, d, e, f);
        verifica("r2_espaco", t - rel, 4);
        verifica("r2_esq0", e, 1);
        verifica("r2_fim", f, 1);
        verifica("r2_pos0", int'(pos_est), 0);
        verifica("r2_sent_sobe", int'(sentido), 0);
        espera_pulso(t, d, e, f);
        verifica("r2_direita", d, 1);
        verifica("r2_direita_pos", int'(pos_est), 1);

        // Asynchronous reset in the cycle direita is high cuts the pulse at once
        reset = 1'b0;
        #1;
        verifica("rst_corta_direita", int'(direita), 0);
        verifica("rst_pos", int'(pos_est), 0);
        verifica("rst_estado", int'(db_estado), 0);
        verifica("rst_sentido", int'(sentido), 0);
        ciclo();
        ciclo();
        reset = 1'b1;
        ciclo();
        verifica("pos_rst_varre", int'(db_estado), 1);
        rel = n_ciclo;
        espera_pulso(t, d, e, f);
        verifica("pos_rst_latencia", t - rel, 4);
        verifica("pos_rst_direita", d, 1);
        verifica("pos_rst_pos", int'(pos_est), 1);

        verifica("monitor_retorno", viol_retorno, 0);
        verifica("monitor_ambos", ambos, 0);

        $display("CHECKS %0d ERRORS %0d", checks, erros);
        $finish;
    end

endmodule
